// File: rtl/ppi_pkg.sv
// rtl/ppi_pkg.sv - shared types and constants for the synchronous PPI
package ppi_pkg;

  // Control-word bit positions (bit 7 = 1 selects a control write, 0 = BSR)
  localparam int CW_FLAG     = 7;
  localparam int CW_AMODE_HI = 6;
  localparam int CW_AMODE_LO = 5;
  localparam int CW_ADIR     = 4;
  localparam int CW_CUDIR    = 3;
  localparam int CW_BMODE    = 2;
  localparam int CW_BDIR     = 1;
  localparam int CW_CLDIR    = 0;

  // Power-up control word: everything mode 0, every port an input
  localparam logic [7:0] CTRL_RESET = 8'h9B;

  // Bus address map
  localparam logic [1:0] ADDR_A    = 2'b00;
  localparam logic [1:0] ADDR_B    = 2'b01;
  localparam logic [1:0] ADDR_C    = 2'b10;
  localparam logic [1:0] ADDR_CTRL = 2'b11;

  // Port C handshake positions in mode 1
  localparam int PC_OBF_A  = 7;
  localparam int PC_ACK_A  = 6;
  localparam int PC_IBF_A  = 5;
  localparam int PC_STB_A  = 4;
  localparam int PC_INTR_A = 3;
  localparam int PC_HS_B   = 2;  // STB_B when B is input, ACK_B when output
  localparam int PC_FLAG_B = 1;  // IBF_B or OBF_B
  localparam int PC_INTR_B = 0;

  typedef enum logic {MODE0 = 1'b0, MODE1 = 1'b1} mode_e;

  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, ACKING = 2'd2} hs_state_e;

  // Group A mode field: 00 is mode 0, anything else behaves as mode 1
  function automatic mode_e a_mode_of(input logic [7:0] cw);
    return (cw[CW_AMODE_HI] | cw[CW_AMODE_LO]) ? MODE1 : MODE0;
  endfunction

endpackage

// File: rtl/ppi_hs_sync_if.sv
// rtl/ppi_hs_sync_if.sv - CPU bus and peripheral port bundle for ppi_hs_sync
interface ppi_hs_sync_if #(parameter int W = 8);
  logic         CSbar;
  logic         RDbar;
  logic         WRbar;
  logic [1:0]   Addresslines;
  logic [W-1:0] d_in;
  logic [W-1:0] d_out;
  logic         d_oe;
  logic [W-1:0] pa_in;
  logic [W-1:0] pa_out;
  logic         pa_oe;
  logic [W-1:0] pb_in;
  logic [W-1:0] pb_out;
  logic         pb_oe;
  logic [7:0]   pc_in;
  logic [7:0]   pc_out;
  logic [7:0]   pc_oe;

  modport master (
    output CSbar, RDbar, WRbar, Addresslines, d_in, pa_in, pb_in, pc_in,
    input  d_out, d_oe, pa_out, pa_oe, pb_out, pb_oe, pc_out, pc_oe
  );

  modport slave (
    input  CSbar, RDbar, WRbar, Addresslines, d_in, pa_in, pb_in, pc_in,
    output d_out, d_oe, pa_out, pa_oe, pb_out, pb_oe, pc_out, pc_oe
  );
endinterface

// File: rtl/ppi_hs_port.sv
// rtl/ppi_hs_port.sv - one port latch with its mode 1 strobe/ack handshake FSM
module ppi_hs_port
  import ppi_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,     // control-word write: drop latch and handshake
  input  mode_e        mode_i,
  input  logic         dir_in_i,    // 1 = port is an input
  input  logic         wr_i,        // CPU write event addressed to this port
  input  logic         rd_start_i,  // CPU read start addressed to this port
  input  logic         rd_end_i,    // CPU read end addressed to this port
  input  logic         inte_i,
  input  logic         hs_n_i,      // STB (input) or ACK (output), active low
  input  logic [W-1:0] d_i,
  input  logic [W-1:0] pins_i,
  output logic [W-1:0] out_o,
  output logic         oe_o,
  output logic [W-1:0] rd_o,
  output logic         flag_o,      // IBF (active high) or OBF (active low)
  output logic         intr_o
);

  hs_state_e    state_q, state_d;
  logic [W-1:0] lat_q, lat_d;
  logic         intr_q, intr_d;
  logic         hs_prev_q;
  logic         hs_fall, hs_rise;

  assign hs_fall = hs_prev_q & ~hs_n_i;
  assign hs_rise = ~hs_prev_q & hs_n_i;

  // State, latch, interrupt and strobe-history registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= EMPTY;
      lat_q     <= '0;
      intr_q    <= 1'b0;
      hs_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      intr_q    <= intr_d;
      hs_prev_q <= hs_n_i;
    end
  end

  // Handshake next state: plain latch in mode 0, strobed FSM in mode 1
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    intr_d  = intr_q;
    if (clear_i) begin
      state_d = EMPTY;
      lat_d   = '0;
      intr_d  = 1'b0;
    end else if (mode_i == MODE0) begin
      state_d = EMPTY;
      intr_d  = 1'b0;
      if (wr_i) lat_d = d_i;
    end else if (dir_in_i) begin
      case (state_q)
        EMPTY: begin
          if (hs_fall) begin
            lat_d   = pins_i;
            state_d = FULL;
          end
        end
        FULL: begin
          if (hs_rise) intr_d = inte_i;
          if (rd_end_i) state_d = EMPTY;
        end
        default: state_d = EMPTY;
      endcase
      if (rd_start_i) intr_d = 1'b0;
    end else begin
      case (state_q)
        FULL:    if (hs_fall) state_d = ACKING;
        ACKING: begin
          if (hs_rise) begin
            intr_d  = inte_i;
            state_d = EMPTY;
          end
        end
        default: state_d = state_q;
      endcase
      // A new write always wins, including one that lands mid-acknowledge
      if (wr_i) begin
        lat_d   = d_i;
        intr_d  = 1'b0;
        state_d = FULL;
      end
    end
  end

  assign oe_o   = ~dir_in_i;
  assign out_o  = dir_in_i ? '0 : lat_q;
  assign rd_o   = (mode_i == MODE0 && dir_in_i) ? pins_i : lat_q;
  assign flag_o = dir_in_i ? (state_q == FULL) : (state_q != FULL);
  assign intr_o = intr_q;

endmodule

// File: rtl/ppi_hs_sync.sv
// rtl/ppi_hs_sync.sv - synchronous 8255-style PPI with mode 1 handshaking
module ppi_hs_sync
  import ppi_pkg::*;
#(
  parameter int W = 8
) (
  input logic           CLK,
  input logic           RESET,
  ppi_hs_sync_if.slave  bus
);

  logic [7:0]   ctrl_q, ctrl_d;
  logic [7:0]   pc_lat_q, pc_lat_d;
  logic         inte_a_q, inte_a_d, inte_b_q, inte_b_d;
  logic         wr_prev_q, rd_prev_q;
  logic         wr_ev, rd_start, rd_end;
  logic         ctrl_wr, bsr_wr;
  logic [2:0]   bsr_bit;
  mode_e        a_mode, b_mode;
  logic         a_in, b_in;
  logic         sel_a, sel_b;
  logic [W-1:0] a_rd, b_rd;
  logic         a_flag, a_intr, b_flag, b_intr;
  logic         a_hs_n;
  logic [7:0]   pc_out_c, pc_oe_c, pc_rd_c;
  logic [W-1:0] d_out_c;

  // Bus events: edges of the strobes qualified by chip select, never both strobes low
  assign wr_ev    = ~bus.CSbar & wr_prev_q & ~bus.WRbar & bus.RDbar;
  assign rd_start = ~bus.CSbar & rd_prev_q & ~bus.RDbar & bus.WRbar;
  assign rd_end   = ~bus.CSbar & ~rd_prev_q & bus.RDbar & bus.WRbar;

  assign ctrl_wr = wr_ev & (bus.Addresslines == ADDR_CTRL) & bus.d_in[CW_FLAG];
  assign bsr_wr  = wr_ev & (bus.Addresslines == ADDR_CTRL) & ~bus.d_in[CW_FLAG];
  assign bsr_bit = bus.d_in[3:1];

  assign a_mode = a_mode_of(ctrl_q);
  assign b_mode = ctrl_q[CW_BMODE] ? MODE1 : MODE0;
  assign a_in   = ctrl_q[CW_ADIR];
  assign b_in   = ctrl_q[CW_BDIR];
  assign sel_a  = (bus.Addresslines == ADDR_A);
  assign sel_b  = (bus.Addresslines == ADDR_B);
  assign a_hs_n = a_in ? bus.pc_in[PC_STB_A] : bus.pc_in[PC_ACK_A];

  // Control word, port C latch, interrupt enables and strobe history
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl_q    <= CTRL_RESET;
      pc_lat_q  <= '0;
      inte_a_q  <= 1'b0;
      inte_b_q  <= 1'b0;
      wr_prev_q <= 1'b1;
      rd_prev_q <= 1'b1;
    end else begin
      ctrl_q    <= ctrl_d;
      pc_lat_q  <= pc_lat_d;
      inte_a_q  <= inte_a_d;
      inte_b_q  <= inte_b_d;
      wr_prev_q <= bus.WRbar;
      rd_prev_q <= bus.RDbar;
    end
  end

  // Control/BSR/port C writes; BSR on a handshake input position sets INTE instead
  always_comb begin
    ctrl_d   = ctrl_q;
    pc_lat_d = pc_lat_q;
    inte_a_d = inte_a_q;
    inte_b_d = inte_b_q;
    if (ctrl_wr) begin
      ctrl_d   = bus.d_in[7:0];
      pc_lat_d = '0;
      inte_a_d = 1'b0;
      inte_b_d = 1'b0;
    end else if (bsr_wr) begin
      if (a_mode == MODE1 && a_in && 32'(bsr_bit) == PC_STB_A)
        inte_a_d = bus.d_in[0];
      else if (a_mode == MODE1 && !a_in && 32'(bsr_bit) == PC_ACK_A)
        inte_a_d = bus.d_in[0];
      else if (b_mode == MODE1 && 32'(bsr_bit) == PC_HS_B)
        inte_b_d = bus.d_in[0];
      else
        pc_lat_d[bsr_bit] = bus.d_in[0];
    end else if (wr_ev && bus.Addresslines == ADDR_C) begin
      pc_lat_d = bus.d_in[7:0];
    end
  end

  ppi_hs_port #(.W(W)) u_port_a (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .clear_i    (ctrl_wr),
    .mode_i     (a_mode),
    .dir_in_i   (a_in),
    .wr_i       (wr_ev & sel_a),
    .rd_start_i (rd_start & sel_a),
    .rd_end_i   (rd_end & sel_a),
    .inte_i     (inte_a_q),
    .hs_n_i     (a_hs_n),
    .d_i        (bus.d_in),
    .pins_i     (bus.pa_in),
    .out_o      (bus.pa_out),
    .oe_o       (bus.pa_oe),
    .rd_o       (a_rd),
    .flag_o     (a_flag),
    .intr_o     (a_intr)
  );

  ppi_hs_port #(.W(W)) u_port_b (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .clear_i    (ctrl_wr),
    .mode_i     (b_mode),
    .dir_in_i   (b_in),
    .wr_i       (wr_ev & sel_b),
    .rd_start_i (rd_start & sel_b),
    .rd_end_i   (rd_end & sel_b),
    .inte_i     (inte_b_q),
    .hs_n_i     (bus.pc_in[PC_HS_B]),
    .d_i        (bus.d_in),
    .pins_i     (bus.pb_in),
    .out_o      (bus.pb_out),
    .oe_o       (bus.pb_oe),
    .rd_o       (b_rd),
    .flag_o     (b_flag),
    .intr_o     (b_intr)
  );

  // Port C pin drive and readback, handshake bits overriding the mode 0 latch
  always_comb begin
    pc_oe_c  = {{4{~ctrl_q[CW_CUDIR]}}, {4{~ctrl_q[CW_CLDIR]}}};
    pc_out_c = pc_lat_q;
    if (a_mode == MODE1) begin
      pc_oe_c[PC_INTR_A]  = 1'b1;
      pc_out_c[PC_INTR_A] = a_intr;
      if (a_in) begin
        pc_oe_c[PC_STB_A]  = 1'b0;
        pc_out_c[PC_STB_A] = 1'b0;
        pc_oe_c[PC_IBF_A]  = 1'b1;
        pc_out_c[PC_IBF_A] = a_flag;
      end else begin
        pc_oe_c[PC_ACK_A]  = 1'b0;
        pc_out_c[PC_ACK_A] = 1'b0;
        pc_oe_c[PC_OBF_A]  = 1'b1;
        pc_out_c[PC_OBF_A] = a_flag;
      end
    end
    if (b_mode == MODE1) begin
      pc_oe_c[PC_HS_B]    = 1'b0;
      pc_out_c[PC_HS_B]   = 1'b0;
      pc_oe_c[PC_FLAG_B]  = 1'b1;
      pc_out_c[PC_FLAG_B] = b_flag;
      pc_oe_c[PC_INTR_B]  = 1'b1;
      pc_out_c[PC_INTR_B] = b_intr;
    end
    pc_rd_c = (pc_out_c & pc_oe_c) | (bus.pc_in & ~pc_oe_c);
    if (a_mode == MODE1) pc_rd_c[a_in ? PC_STB_A : PC_ACK_A] = inte_a_q;
    if (b_mode == MODE1) pc_rd_c[PC_HS_B] = inte_b_q;
  end

  // CPU read mux, combinational so data is valid while RDbar is low
  always_comb begin
    case (bus.Addresslines)
      ADDR_A:  d_out_c = a_rd;
      ADDR_B:  d_out_c = b_rd;
      ADDR_C:  d_out_c = W'(pc_rd_c);
      default: d_out_c = W'(ctrl_q);
    endcase
  end

  assign bus.d_out  = d_out_c;
  assign bus.d_oe   = ~bus.CSbar & ~bus.RDbar & bus.WRbar;
  assign bus.pc_out = pc_out_c;
  assign bus.pc_oe  = pc_oe_c;

endmodule

// File: tb/tb_ppi_hs_sync.sv
// tb/tb_ppi_hs_sync.sv - scoreboard bench for ppi_hs_sync
module tb_ppi_hs_sync;
  localparam int W = 8;
  localparam int SEL_DOUT = 0, SEL_DOE = 1, SEL_PAOUT = 2, SEL_PAOE = 3;
  localparam int SEL_PBOUT = 4, SEL_PBOE = 5, SEL_PCOUT = 6, SEL_PCOE = 7;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  ppi_hs_sync_if #(.W(W)) bus ();
  ppi_hs_sync #(.W(W)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  string       tag_q[$];
  int          sel_q[$];
  logic [31:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_DOUT:  return 32'(bus.d_out);
      SEL_DOE:   return 32'(bus.d_oe);
      SEL_PAOUT: return 32'(bus.pa_out);
      SEL_PAOE:  return 32'(bus.pa_oe);
      SEL_PBOUT: return 32'(bus.pb_out);
      SEL_PBOE:  return 32'(bus.pb_oe);
      SEL_PCOUT: return 32'(bus.pc_out);
      default:   return 32'(bus.pc_oe);
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sel, input logic [31:0] exp);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_q.push_back(exp);
  endtask

  task automatic drain();
    string t;
    int s;
    logic [31:0] e;
    while (tag_q.size() > 0) begin
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      check_val(t, observe(s), e);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Write cycle: expectations queued beforehand are checked the cycle after the event
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus.Addresslines = a;
    bus.d_in = d;
    bus.CSbar = 1'b0;
    bus.WRbar = 1'b0;
    tick();
    drain();
    bus.WRbar = 1'b1;
    bus.CSbar = 1'b1;
    tick();
  endtask

  // Simple read: d_out checked while RDbar is low
  task automatic bus_read(input string tag, input logic [1:0] a, input logic [7:0] exp);
    bus.Addresslines = a;
    bus.CSbar = 1'b0;
    bus.RDbar = 1'b0;
    #1;
    expect_v(tag, SEL_DOUT, 32'(exp));
    drain();
    tick();
    bus.RDbar = 1'b1;
    tick();
    bus.CSbar = 1'b1;
    tick();
  endtask

  task automatic pc_pin(input logic [7:0] v);
    bus.pc_in = v;
    tick();
  endtask

  initial begin
    bus.CSbar = 1'b1; bus.RDbar = 1'b1; bus.WRbar = 1'b1;
    bus.Addresslines = 2'b00; bus.d_in = '0;
    bus.pa_in = '0; bus.pb_in = '0; bus.pc_in = 8'hFF;
    RESET = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    tick();

    // Reset state
    expect_v("rst_pa_oe", SEL_PAOE, 0);
    expect_v("rst_pb_oe", SEL_PBOE, 0);
    expect_v("rst_pc_oe", SEL_PCOE, 0);
    expect_v("rst_pa_out", SEL_PAOUT, 0);
    expect_v("rst_pb_out", SEL_PBOUT, 0);
    expect_v("rst_pc_out", SEL_PCOUT, 0);
    expect_v("rst_d_oe", SEL_DOE, 0);
    drain();

    // Mode 0 input reads return pins
    bus.pa_in = 8'h5A;
    bus.pb_in = 8'h33;
    bus.Addresslines = 2'b00; bus.CSbar = 1'b0; bus.RDbar = 1'b0;
    #1;
    expect_v("rd_oe", SEL_DOE, 1);
    drain();
    bus.RDbar = 1'b1; bus.CSbar = 1'b1;
    tick();
    bus_read("rd_a_pins", 2'b00, 8'h5A);
    bus_read("rd_b_pins", 2'b01, 8'h33);
    bus_read("rd_ctrl_rst", 2'b11, 8'h9B);

    // Mode 0, all outputs
    expect_v("m0_pc_oe", SEL_PCOE, 8'hFF);
    expect_v("m0_pa_oe", SEL_PAOE, 1);
    bus_write(2'b11, 8'h80);
    expect_v("m0_pa_out", SEL_PAOUT, 8'hAA);
    expect_v("m0_pa_oe2", SEL_PAOE, 1);
    bus_write(2'b00, 8'hAA);
    bus_read("m0_rd_a_latch", 2'b00, 8'hAA);
    expect_v("m0_pb_out", SEL_PBOUT, 8'h55);
    bus_write(2'b01, 8'h55);
    bus_read("m0_rd_b_latch", 2'b01, 8'h55);

    // BSR set/reset leaves other bits alone
    expect_v("bsr_pc7", SEL_PCOUT, 8'h80);
    bus_write(2'b11, 8'h0F);
    expect_v("bsr_pc5_set", SEL_PCOUT, 8'hA0);
    bus_write(2'b11, 8'h0B);
    expect_v("bsr_pc5_clr", SEL_PCOUT, 8'h80);
    bus_write(2'b11, 8'h0A);
    expect_v("m0_pc_wr", SEL_PCOUT, 8'h5C);
    bus_write(2'b10, 8'h5C);
    bus_read("m0_rd_c", 2'b10, 8'h5C);

    // Mode 1 input on A
    expect_v("m1i_pc_oe", SEL_PCOE, 8'hEF);
    expect_v("m1i_pc_out", SEL_PCOUT, 8'h00);
    expect_v("m1i_pa_oe", SEL_PAOE, 0);
    expect_v("m1i_pb_out", SEL_PBOUT, 8'h00);
    bus_write(2'b11, 8'hB0);
    bus_write(2'b11, 8'h09);
    bus_read("m1i_rd_c_inte", 2'b10, 8'h10);
    bus.pa_in = 8'h3C;
    pc_pin(8'hEF);
    expect_v("m1i_ibf", SEL_PCOUT, 8'h20);
    drain();
    pc_pin(8'hFF);
    expect_v("m1i_intr", SEL_PCOUT, 8'h28);
    drain();
    bus.pa_in = 8'hC3;
    pc_pin(8'hEF);
    pc_pin(8'hFF);
    expect_v("m1i_full_hold", SEL_PCOUT, 8'h28);
    drain();
    bus.Addresslines = 2'b00; bus.CSbar = 1'b0; bus.RDbar = 1'b0;
    #1;
    expect_v("m1i_rd_a", SEL_DOUT, 8'h3C);
    drain();
    tick();
    expect_v("m1i_intr_clr", SEL_PCOUT, 8'h20);
    drain();
    bus.RDbar = 1'b1;
    tick();
    expect_v("m1i_ibf_clr", SEL_PCOUT, 8'h00);
    drain();
    bus.CSbar = 1'b1;
    tick();

    // Mode 1 output on A
    expect_v("m1o_pc_oe", SEL_PCOE, 8'hBF);
    expect_v("m1o_obf_idle", SEL_PCOUT, 8'h80);
    bus_write(2'b11, 8'hA0);
    bus_write(2'b11, 8'h0D);
    expect_v("m1o_obf_act", SEL_PCOUT, 8'h00);
    expect_v("m1o_pa_out", SEL_PAOUT, 8'h77);
    bus_write(2'b00, 8'h77);
    pc_pin(8'hBF);
    expect_v("m1o_ack_lo", SEL_PCOUT, 8'h80);
    drain();
    pc_pin(8'hFF);
    expect_v("m1o_intr", SEL_PCOUT, 8'h88);
    drain();
    bus_read("m1o_rd_c", 2'b10, 8'hC8);
    pc_pin(8'hBF);
    pc_pin(8'hFF);
    expect_v("m1o_ack_empty", SEL_PCOUT, 8'h88);
    drain();
    expect_v("m1o_rewrite", SEL_PCOUT, 8'h00);
    expect_v("m1o_pa_out2", SEL_PAOUT, 8'h11);
    bus_write(2'b00, 8'h11);

    // Reset in the middle of a handshake
    RESET = 1'b1;
    tick();
    expect_v("mid_rst_pc_out", SEL_PCOUT, 0);
    expect_v("mid_rst_pc_oe", SEL_PCOE, 0);
    expect_v("mid_rst_pa_oe", SEL_PAOE, 0);
    expect_v("mid_rst_pa_out", SEL_PAOUT, 0);
    expect_v("mid_rst_pb_oe", SEL_PBOE, 0);
    drain();
    RESET = 1'b0;
    pc_pin(8'hBF);
    pc_pin(8'hFF);
    expect_v("mid_rst_no_intr", SEL_PCOUT, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ppi_hs_sync.md
# ppi_hs_sync

Synchronous, parametrised successor to the team's 8255-style programmable peripheral interface. Adds a clock, registered port latches, a parametrised port width, and 8255 mode 1 strobed handshaking on ports A and B; BSR and mode 0 are kept. Sits between the CPU bus (CSbar/RDbar/WRbar/Addresslines) and external peripherals. Tri-states are split into in/out/oe triples, resolved at the pad level.

## Interface
- W, 8: width of data bus and ports A/B; must be ≥ 8; control/BSR words use bits [7:0].
- CLK  in  1  single clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- CSbar, RDbar, WRbar  in  1  active-low bus strobes, synchronous to CLK.
- Addresslines  in  2  00=A, 01=B, 10=C, 11=control.
- d_in  in  W  CPU write data.
- d_out  out  W  CPU read data.
- d_oe  out  1  = !CSbar & !RDbar & WRbar.
- pa_in / pa_out / pa_oe  in/out/out  W/W/1  port A.
- pb_in / pb_out / pb_oe  in/out/out  W/W/1  port B.
- pc_in / pc_out / pc_oe  in/out/out  8/8/8  port C, per-bit oe.
- External inputs are already synchronised to CLK.

## Operation
- Events, each decoded with CSbar=0 in the same cycle: wr_ev = WRbar 1→0; rd_start = RDbar 1→0; rd_end = RDbar 0→1. Previous WRbar/RDbar values are registered. Simultaneous RDbar=0 and WRbar=0: no event.
- Control word, written at address 11 with d_in[7]=1:
  - [6:5] A mode (00 = mode 0, 01 = mode 1; 1x is treated as 01).
  - [4] A dir, [3] C-upper dir, [2] B mode, [1] B dir, [0] C-lower dir. Dir: 1 = input.
  - Effects: all output latches cleared to 0; INTE_A/INTE_B cleared; handshake FSMs go to idle.
- BSR, written at address 11 with d_in[7]=0: pc latch bit d_in[3:1] ← d_in[0].
  - If that bit is a mode-1 handshake input position, the write sets INTE instead: A-in PC4, A-out PC6, B PC2.
- Mode 0: writes go to port latches. Reads return pin value for input ports and the latch for output ports.
- Mode 1, port A (control PC7–PC3); port B uses PC2–PC0.
  - A input: STB_A=PC4 (in, low active), IBF_A=PC5 (out), INTR_A=PC3.
  - A output: OBF_A=PC7 (out, low active), ACK_A=PC6 (in, low active).
  - B input: STB_B=PC2, IBF_B=PC1, INTR_B=PC0.
  - B output: ACK_B=PC2, OBF_B=PC1, INTR_B=PC0.
  - Remaining PC bits behave as mode 0 per their C dir.
- Input handshake FSM: EMPTY → FULL.
  - STB 1→0 in EMPTY: latch port pins, IBF=1.
  - STB 0→1 in FULL: INTR ← INTE.
  - rd_start on the port: INTR=0. rd_end: IBF=0, go to EMPTY.
  - STB 1→0 in FULL: ignored; latch unchanged.
- Output handshake FSM: EMPTY → FULL → ACKING → EMPTY.
  - wr_ev on the port: latch d_in, OBF=0 (asserted), INTR=0, go to FULL.
  - ACK 1→0 in FULL: OBF=1, go to ACKING.
  - ACK 0→1 in ACKING: INTR ← INTE, go to EMPTY.
  - ACK while EMPTY: ignored.
  - wr_ev in ACKING: new data latched, OBF=0, go to FULL.
- Port C read returns pc_in for input bits and the latch/handshake value for output bits. Mode-1 handshake input positions read back the INTE flags.

## Timing
- Latency: every event updates state at the end of its detection cycle; outputs change on the next cycle.
- Strobe pulses on STB/ACK are held ≥ 1 CLK.
- d_out is combinational from registered state, valid in the same cycle as RDbar=0.
- Reset values:
  - Control word 8'h9B (all mode 0, all ports input).
  - All *_out = 0; pa_oe = pb_oe = 0; pc_oe = 0; d_oe follows its equation.
  - INTE = 0; FSMs EMPTY.
  - Entering mode 1 output sets OBF = 1 (inactive); IBF = 0.
- RESET mid-handshake aborts it; no INTR is produced.

## Structure
- Package ppi_pkg holds:
  - Control-word bit positions.
  - Mode enum (MODE0, MODE1).
  - PC handshake bit indices.
  - FSM state enum (EMPTY, FULL, ACKING).
  - Reset control word constant.
- Sub-module ppi_hs_port: one handshake FSM plus port latch, parametrised by W and direction. Instantiated twice, for A and B.

## Test plan
- Reset, then read A with pa_in=8'h5A → d_out=8'h5A; all oe = 0.
- Write control 8'h80, then write A 8'hAA → pa_oe=1 and pa_out=8'hAA on the next cycle; pc_oe=8'hFF.
- BSR 8'h0B then 8'h0A → pc_out[5] = 1, then 0; other bits unchanged.
- Control 8'hB0, BSR 8'h09 (INTE_A=1), pulse PC4 low with pa_in=8'h3C:
  - IBF=1, then INTR=1 after the PC4 rise.
  - A read returns 8'h3C; INTR clears at rd_start, IBF at rd_end.
  - A second STB while FULL keeps 8'h3C.
- Control 8'hA0, INTE via BSR 8'h0D, write A 8'h77:
  - PC7=0; ACK low sets PC7=1; ACK high sets PC3=1.
- RESET asserted while port A is in FULL → next cycle all outputs at reset values, INTR = 0.
